// File: rtl/grad_pkg.sv
// Shared constants and the output-beat type for the gradient sum-of-squares stage.
package grad_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 11;
    localparam int unsigned OUT_WIDTH_DEF = 21;

    // One result beat as held in the final pipeline stage.
    // The sum field is sized from the package default. Change OUT_WIDTH_DEF together
    // with any override of OUT_WIDTH.
    typedef struct packed {
        logic [OUT_WIDTH_DEF-1:0] sum;
        logic                     sof;
        logic                     eol;
        logic                     ovf;
    } beat_t;

endpackage

// File: rtl/abs_sq.sv
// Two registered steps for one signed operand: |x| first, then |x|^2.
// Each step loads only when the parent pipeline says that stage advances.
module abs_sq #(
    parameter int unsigned W = 11
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           s1_en_i,
    input  logic           s2_en_i,
    input  logic [W-1:0]   x_i,
    output logic [2*W-1:0] sq_o
);

    logic [W-1:0]   abs_d, abs_q;
    logic [2*W-1:0] sq_d, sq_q;

    // Magnitude fits unsigned W bits, including the most negative input.
    always_comb begin
        abs_d = x_i[W-1] ? -x_i : x_i;
        sq_d  = {{W{1'b0}}, abs_q} * {{W{1'b0}}, abs_q};
    end

    // Stage registers, loaded under the parent's advance enables.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            abs_q <= '0;
            sq_q  <= '0;
        end else begin
            if (s1_en_i) abs_q <= abs_d;
            if (s2_en_i) sq_q  <= sq_d;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/grad_sq_sum.sv
// Gradient sum of squares: out_sum = gx*gx + gy*gy through a 3-stage
// valid/ready pipeline, with a per-frame overflow counter.
// Optional feature: define GRAD_SQ_SUM_SAT_EN to clamp overflowed sums to all-ones.
// Without it, the sum wraps modulo 2^OUT_WIDTH.
module grad_sq_sum
    import grad_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  gx,
    input  logic [IN_WIDTH-1:0]  gy,
    input  logic                 in_sof,
    input  logic                 in_eol,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_sum,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic [15:0]          ovf_cnt
);

    // Full-precision sum width. It must exceed OUT_WIDTH so that overflow is visible.
    localparam int unsigned SumW = 2 * IN_WIDTH + 1;

    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s3_valid_d, s3_valid_q;
    logic s1_sof_q, s1_eol_q, s2_sof_q, s2_eol_q;
    logic s1_ready, s2_ready, s3_ready;
    logic s1_load, s2_load, s3_load, out_fire;

    logic [2*IN_WIDTH-1:0] sq_x, sq_y;
    logic [SumW-1:0]       full_sum;
    logic                  sum_ovf;
    beat_t                 s3_d, s3_q;
    logic [15:0]           ovf_cnt_d, ovf_cnt_q;

    // Handshake: a stage accepts when empty or when it drains this cycle.
    always_comb begin
        s3_ready   = !s3_valid_q || out_ready;
        s2_ready   = !s2_valid_q || s3_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        s1_load    = in_valid && s1_ready;
        s2_load    = s1_valid_q && s2_ready;
        s3_load    = s2_valid_q && s3_ready;
        out_fire   = s3_valid_q && out_ready;
        s1_valid_d = s1_ready ? in_valid   : s1_valid_q;
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s3_valid_d = s3_ready ? s2_valid_q : s3_valid_q;
    end

    abs_sq #(
        .W (IN_WIDTH)
    ) u_abs_sq_x (
        .clk_i   (clk),
        .rst_ni  (sys_rst_n),
        .s1_en_i (s1_load),
        .s2_en_i (s2_load),
        .x_i     (gx),
        .sq_o    (sq_x)
    );

    abs_sq #(
        .W (IN_WIDTH)
    ) u_abs_sq_y (
        .clk_i   (clk),
        .rst_ni  (sys_rst_n),
        .s1_en_i (s1_load),
        .s2_en_i (s2_load),
        .x_i     (gy),
        .sq_o    (sq_y)
    );

    // Final-stage beat: sum, overflow detection, and the optional clamp.
    always_comb begin
        full_sum = {1'b0, sq_x} + {1'b0, sq_y};
        sum_ovf  = |full_sum[SumW-1:OUT_WIDTH];
        s3_d     = '0;
`ifdef GRAD_SQ_SUM_SAT_EN
        s3_d.sum = sum_ovf ? '1 : full_sum[OUT_WIDTH-1:0];
`else
        s3_d.sum = full_sum[OUT_WIDTH-1:0];
`endif
        s3_d.sof = s2_sof_q;
        s3_d.eol = s2_eol_q;
        s3_d.ovf = sum_ovf;
    end

    // Overflow counter: a sof beat restarts the count, and the count saturates at all-ones.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (out_fire) begin
            if (s3_q.sof) begin
                ovf_cnt_d = {15'd0, s3_q.ovf};
            end else if (s3_q.ovf && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    // Pipeline state: stage valids, marker sidebands, final beat and counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            s3_q       <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            if (s1_load) begin
                s1_sof_q <= in_sof;
                s1_eol_q <= in_eol;
            end
            if (s2_load) begin
                s2_sof_q <= s1_sof_q;
                s2_eol_q <= s1_eol_q;
            end
            if (s3_load) s3_q <= s3_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s3_valid_q;
    assign out_sum   = s3_q.sum;
    assign out_sof   = s3_q.sof;
    assign out_eol   = s3_q.eol;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_grad_sq_sum.sv
// Scoreboard bench for grad_sq_sum: the driver pushes expected beats and a
// monitor pops and compares them on every output handshake.
module tb_grad_sq_sum;

    logic        clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] gx;
    logic [10:0] gy;
    logic        in_sof;
    logic        in_eol;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_sum;
    logic        out_sof;
    logic        out_eol;
    logic [15:0] ovf_cnt;

    typedef struct {
        int sum;
        bit sof;
        bit eol;
        int acc;
        bit lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   stall_cnt;
    int   streak;
    int   max_streak;
    int   valid_seen;

    grad_sq_sum u_dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gx        (gx),
        .gy        (gy),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .ovf_cnt   (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endfunction

    // Reference sum: wraps at 2^21, or clamps when saturation is built in.
    function automatic int exp_sum(input int x, input int y);
        int full;
        full = x * x + y * y;
        if (full >= 2097152) begin
`ifdef GRAD_SQ_SUM_SAT_EN
            return 2097151;
`else
            return full % 2097152;
`endif
        end
        return full;
    endfunction

    // Present one beat, wait (bounded) for acceptance, then push its expected result.
    task automatic send(input int x, input int y, input bit sof, input bit eol, input bit lat);
        exp_t e;
        bit   acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        gx       = x[10:0];
        gy       = y[10:0];
        in_sof   = sof;
        in_eol   = eol;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum = exp_sum(x, y);
                e.sof = sof;
                e.eol = eol;
                e.acc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
                acc = 1'b1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("accept_timeout", longint'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", longint'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output handshake, and check that a stalled beat is held.
    initial begin
        logic        stall_prev;
        logic [22:0] held;
        exp_t        e;
        stall_prev = 1'b0;
        held       = '0;
        streak     = 0;
        max_streak = 0;
        forever begin
            @(negedge clk);
            if (!sys_rst_n) begin
                stall_prev = 1'b0;
                streak     = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", longint'(out_valid), 1);
                    check("hold_beat", longint'({out_sof, out_eol, out_sum}), longint'(held));
                end
                if (out_valid) begin
                    streak++;
                    if (streak > max_streak) max_streak = streak;
                end else begin
                    streak = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_beat: got sum %0d, required no beat", out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_sum", longint'(out_sum), longint'(e.sum));
                        check("markers", longint'({out_sof, out_eol}), longint'({e.sof, e.eol}));
                        if (e.lat) check("latency", longint'(cyc - e.acc), 3);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_sof, out_eol, out_sum};
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        stall_cnt  = 0;
        sys_rst_n  = 1'b0;
        in_valid   = 1'b0;
        gx         = '0;
        gy         = '0;
        in_sof     = 1'b0;
        in_eol     = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        check("rst_ovf_cnt", longint'(ovf_cnt), 0);
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);

        // Basic: 3, -4 -> 25 with latency 3
        send(3, -4, 1'b0, 1'b0, 1'b1);
        drain();

        // Throughput: 100 back-to-back beats
        stall_cnt = 0;
        for (int i = 0; i < 100; i++) send(i, 0, i == 0, i == 99, 1'b1);
        drain();
        check("tput_no_stall", longint'(stall_cnt), 0);
        check("tput_streak", longint'(max_streak), 100);

        // Backpressure: out_ready low for 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 12; i++) send(i + 5, -2 * i, 1'b0, i[0], 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                check("bp_in_ready_low", longint'(in_ready), 0);
                @(negedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Overflow with sof, then the largest non-overflowing sums
        send(-1024, -1024, 1'b1, 1'b0, 1'b1);
        send(-1024, 0, 1'b0, 1'b0, 1'b1);
        send(1023, 1023, 1'b0, 1'b1, 1'b1);
        drain();
`ifdef GRAD_SQ_SUM_SAT_EN
        check("ovf_cnt_sat_build", longint'(ovf_cnt), 1);
`else
        check("ovf_cnt_wrap_build", longint'(ovf_cnt), 1);
`endif

        // Frame: two more overflows in frame 1, then frame 2's sof beat overflows
        send(-1024, -1024, 1'b0, 1'b0, 1'b0);
        send(-1024, -1024, 1'b0, 1'b1, 1'b0);
        drain();
        check("frame1_ovf_cnt", longint'(ovf_cnt), 3);
        send(-1024, -1024, 1'b1, 1'b0, 1'b0);
        drain();
        check("frame2_sof_ovf_cnt", longint'(ovf_cnt), 1);
        send(1, 1, 1'b1, 1'b0, 1'b0);
        drain();
        check("sof_clean_ovf_cnt", longint'(ovf_cnt), 0);
        send(-1024, -1024, 1'b0, 1'b0, 1'b0);
        drain();
        check("frame3_ovf_cnt", longint'(ovf_cnt), 1);

        // Reset with 3 beats in flight
        send(7, 9, 1'b1, 1'b0, 1'b0);
        send(10, 11, 1'b0, 1'b0, 1'b0);
        send(-1024, -1024, 1'b0, 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_sum", longint'(out_sum), 0);
        check("midrst_ovf_cnt", longint'(ovf_cnt), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        sys_rst_n  = 1'b1;
        valid_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) valid_seen++;
        end
        check("no_stale_beats", longint'(valid_seen), 0);
        @(posedge clk);
        #1;
        send(6, 8, 1'b0, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grad_sq_sum.md
GRAD_SQ_SUM -- requirements
Module: grad_sq_sum

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 11: width of each signed gradient input (two's complement).
REQ-002 SHALL have parameter OUT_WIDTH, default 21: width of the unsigned sum-of-squares output; this equals the radical width of the downstream square-root stage.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: gx/gy/in_sof/in_eol are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-007 SHALL have ports gx and gy, input, IN_WIDTH bits each: signed horizontal and vertical gradients.
REQ-008 SHALL have ports in_sof and in_eol, input, 1 bit each: start-of-frame and end-of-line markers.
REQ-009 SHALL have port out_valid, output, 1 bit: out_sum/out_sof/out_eol are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the output beat.
REQ-011 SHALL have port out_sum, output, OUT_WIDTH bits: gx*gx + gy*gy.
REQ-012 SHALL have ports out_sof and out_eol, output, 1 bit each: the input markers delayed to align with out_sum.
REQ-013 SHALL have port ovf_cnt, output, 16 bits: the number of overflowed results in the current frame.

Function
REQ-014 SHALL accept a beat when in_valid and in_ready are both high, and SHALL emit a beat when out_valid and out_ready are both high.
REQ-015 SHALL use a 3-stage pipeline:
- S1 registers |gx| and |gy| as IN_WIDTH-bit unsigned values; |-1024| = 1024.
- S2 registers the squares, each 2*IN_WIDTH bits.
- S3 registers the (OUT_WIDTH+1)-bit sum together with the markers.
S3 drives all outputs.
REQ-016 SHALL have a latency of exactly 3 cycles from acceptance to out_valid when out_ready is held high.
REQ-017 SHALL give each stage its own valid bit. A stage SHALL load when it is empty or when its contents move on in the same cycle, so bubbles collapse.
REQ-018 SHALL drive in_ready combinationally as (!S1_valid || S1 advances), and SHALL sustain 1 beat per cycle under continuous ready.
REQ-019 SHALL hold out_sum, out_sof and out_eol stable while out_valid is high and out_ready is low.
REQ-020 SHALL raise an internal overflow flag when the full sum is at least 2^OUT_WIDTH; the only case at default widths is gx = gy = -1024.
REQ-021 SHALL increment ovf_cnt once for each output beat that carries the overflow flag, saturating at 0xFFFF.
REQ-022 SHALL set ovf_cnt to 0 on an output beat with out_sof = 1, or to 1 if that same beat also overflowed.
REQ-023 SHALL pass in_sof and in_eol through unmodified and perform no framing checks.

Reset
REQ-024 SHALL, while sys_rst_n is low, asynchronously clear all stage valid bits and set out_valid = 0, out_sum = 0, out_sof = 0, out_eol = 0 and ovf_cnt = 0.
REQ-025 SHALL set in_ready = 1 from the first clock edge after reset deasserts.
REQ-026 SHALL discard any in-flight beats when reset is asserted mid-stream, with no partial output afterwards.

Configuration
REQ-027 SHALL, when macro GRAD_SQ_SUM_SAT_EN is defined, clamp an overflowed out_sum to 2^OUT_WIDTH-1 (2097151 at defaults).
REQ-028 SHALL, when GRAD_SQ_SUM_SAT_EN is undefined, output the sum modulo 2^OUT_WIDTH (0 for gx = gy = -1024).
REQ-029 SHALL count overflows in ovf_cnt regardless of the macro.

Structure
REQ-030 SHALL take the default IN_WIDTH and OUT_WIDTH constants, plus a beat struct {sum, sof, eol, ovf}, from a shared package grad_pkg.
REQ-031 SHALL instantiate one sub-module, abs_sq, which registers |x| and then x^2 and is used twice (gx and gy).

Verification
REQ-032 Basic: gx = 3, gy = -4, out_ready = 1 -> out_sum = 25 exactly 3 cycles after acceptance.
REQ-033 Throughput: 100 back-to-back beats, gx = i, gy = 0, out_ready = 1 -> 100 consecutive out_valid cycles, out_sum = i*i, in_ready never low.
REQ-034 Backpressure: out_ready low for 5 cycles mid-stream -> out_sum held stable, in_ready low once S1..S3 are full, no beat lost or duplicated, order preserved.
REQ-035 Overflow: gx = gy = -1024 -> out_sum = 2097151 with GRAD_SQ_SUM_SAT_EN, 0 without; ovf_cnt = 1.
REQ-036 Frame: gx = gy = -1024 with in_sof on the first beat of frame 2 -> ovf_cnt counts overflows in frame 1, then becomes 1 on frame 2's sof beat.
REQ-037 Reset: assert sys_rst_n low with 3 beats in flight -> out_valid = 0 immediately, and no stale beats appear after release.
